// File: rtl/oc8051_psw_flag_wb.sv
// PSW write-back: commits ALU flags (single- or multi-cycle) and SFR writes, holds PSW.
// Optional OC8051_PSW_F1_EN makes PSW[1] (F1) a writable user flag; otherwise it reads 0.
module oc8051_psw_flag_wb #(
   parameter logic [7:0] PSW_ADDR = 8'hD0,
   parameter logic [7:0] RST_VAL  = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] psw_set,
   input  logic       cy_in,
   input  logic       ac_in,
   input  logic       ov_in,
   input  logic       mc_start,
   input  logic       mc_done,
   input  logic [7:0] acc,
   input  logic       wr,
   input  logic       wr_bit,
   input  logic [7:0] wr_addr,
   input  logic [7:0] data_in,
   input  logic       bit_in,
   output logic [7:0] data_out,
   output logic       cy_out,
   output logic [1:0] bank_sel,
   output logic       busy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   // Bits that SFR writes may touch; parity is never writable.
`ifdef OC8051_PSW_F1_EN
   localparam logic [7:0] WR_MASK = 8'hFE;
`else
   localparam logic [7:0] WR_MASK = 8'hFC;
`endif

   logic [7:0] psw_q;
   logic [7:0] psw_nxt;
   logic [0:0] state_q;
   logic [0:0] state_nxt;
   logic [1:0] sel_q;
   logic [1:0] sel_nxt;
   logic [1:0] commit_sel;
   logic       mc_commit;
   logic [7:0] flag_mask;
   logic [7:0] flag_val;
   logic [7:0] psw_flag;
   logic       byte_hit;
   logic       bit_hit;
   logic [7:0] wr_mask;
   logic [7:0] wr_val;

   // State, pending select and PSW registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= 2'b00;
         busy    <= 1'b0;
         psw_q   <= (RST_VAL & WR_MASK) | {7'b0, ^acc};
      end else begin
         state_q <= state_nxt;
         sel_q   <= sel_nxt;
         busy    <= (state_nxt == ST_WAIT);
         psw_q   <= psw_nxt;
      end
   end

   // Next state and the flag select to commit this cycle.
   always_comb begin
      state_nxt  = state_q;
      sel_nxt    = sel_q;
      commit_sel = 2'b00;
      mc_commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mc_start) begin
               if (psw_set != 2'b00) begin
                  sel_nxt   = psw_set;
                  state_nxt = ST_WAIT;
               end
            end else begin
               commit_sel = psw_set;
            end
         end
         ST_WAIT: begin
            if (mc_done) begin
               commit_sel = sel_q;
               mc_commit  = 1'b1;
               sel_nxt    = 2'b00;
               state_nxt  = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            sel_nxt   = 2'b00;
         end
      endcase
   end

   // Flags first, then the SFR write, except where a multi-cycle result must win.
   always_comb begin
      case (commit_sel)
         2'b01:   flag_mask = 8'h80;
         2'b10:   flag_mask = 8'hC4;
         2'b11:   flag_mask = 8'h84;
         default: flag_mask = 8'h00;
      endcase
      flag_val = {cy_in, ac_in, 3'b000, ov_in, 2'b00};
      psw_flag = (psw_q & ~flag_mask) | (flag_val & flag_mask);

      byte_hit = wr && !wr_bit && (wr_addr == PSW_ADDR);
      bit_hit  = wr && wr_bit && (wr_addr[7:3] == PSW_ADDR[7:3]);
      wr_mask  = 8'h00;
      if (byte_hit) begin
         wr_mask = 8'hFF;
      end else if (bit_hit) begin
         wr_mask = 8'(1'b1) << wr_addr[2:0];
      end
      wr_mask = wr_mask & WR_MASK;
      if (mc_commit) begin
         wr_mask = wr_mask & ~flag_mask;
      end
      wr_val = wr_bit ? {8{bit_in}} : data_in;

      psw_nxt    = (psw_flag & ~wr_mask) | (wr_val & wr_mask);
      psw_nxt[0] = ^acc;
   end

   assign data_out = psw_q;
   assign cy_out   = psw_q[7];
   assign bank_sel = psw_q[4:3];

endmodule

// File: tb/tb_oc8051_psw_flag_wb.sv
// Bench for oc8051_psw_flag_wb: directed plan steps, then random traffic against a flag-level model.
module tb_oc8051_psw_flag_wb;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] psw_set;
   logic       cy_in, ac_in, ov_in;
   logic       mc_start, mc_done;
   logic [7:0] acc;
   logic       wr, wr_bit;
   logic [7:0] wr_addr;
   logic [7:0] data_in;
   logic       bit_in;
   logic [7:0] data_out;
   logic       cy_out;
   logic [1:0] bank_sel;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Reference state: PSW as individual bits plus the deferred-op bookkeeping.
   bit         m_bit [8];
   bit         m_busy;
   int         m_pending;

   oc8051_psw_flag_wb dut (
      .clk(clk), .rst(rst), .psw_set(psw_set), .cy_in(cy_in), .ac_in(ac_in),
      .ov_in(ov_in), .mc_start(mc_start), .mc_done(mc_done), .acc(acc),
      .wr(wr), .wr_bit(wr_bit), .wr_addr(wr_addr), .data_in(data_in),
      .bit_in(bit_in), .data_out(data_out), .cy_out(cy_out),
      .bank_sel(bank_sel), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic bit f1_writable();
`ifdef OC8051_PSW_F1_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] m_byte();
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = m_bit[i];
      return b;
   endfunction

   // Does flag-select s update PSW bit i (CY=7, AC=6, OV=2)?
   function automatic bit sel_hits(int s, int i);
      if (i == 7) return s != 0;
      if (i == 6) return s == 2;
      if (i == 2) return s == 2 || s == 3;
      return 1'b0;
   endfunction

   task automatic model_step();
      int  csel;
      bit  mc;
      bit  nb [8];
      int  parity;
      parity = 0;
      for (int i = 0; i < 8; i++) parity += int'(acc[i]);
      if (rst) begin
         for (int i = 1; i < 8; i++) m_bit[i] = 1'b0;
         m_bit[0]  = bit'(parity % 2);
         m_busy    = 1'b0;
         m_pending = 0;
         return;
      end
      csel = 0;
      mc   = 1'b0;
      if (!m_busy) begin
         if (mc_start) begin
            if (psw_set != 2'b00) begin
               m_pending = int'(psw_set);
               m_busy    = 1'b1;
            end
         end else begin
            csel = int'(psw_set);
         end
      end else if (mc_done) begin
         csel      = m_pending;
         mc        = 1'b1;
         m_pending = 0;
         m_busy    = 1'b0;
      end
      for (int i = 0; i < 8; i++) nb[i] = m_bit[i];
      if (sel_hits(csel, 7)) nb[7] = cy_in;
      if (sel_hits(csel, 6)) nb[6] = ac_in;
      if (sel_hits(csel, 2)) nb[2] = ov_in;
      for (int i = 1; i < 8; i++) begin
         bit touched;
         bit val;
         touched = 1'b0;
         val     = 1'b0;
         if (wr && !wr_bit && wr_addr == 8'hD0) begin
            touched = 1'b1;
            val     = data_in[i];
         end else if (wr && wr_bit && wr_addr >= 8'hD0 && wr_addr <= 8'hD7
                      && int'(wr_addr - 8'hD0) == i) begin
            touched = 1'b1;
            val     = bit_in;
         end
         if (i == 1 && !f1_writable()) touched = 1'b0;
         if (mc && sel_hits(csel, i)) touched = 1'b0;
         if (touched) nb[i] = val;
      end
      nb[0] = bit'(parity % 2);
      for (int i = 0; i < 8; i++) m_bit[i] = nb[i];
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      logic [7:0] e;
      e = m_byte();
      chk({tag, "/data_out"}, data_out, e);
      chk({tag, "/cy_out"}, {7'b0, cy_out}, {7'b0, e[7]});
      chk({tag, "/bank_sel"}, {6'b0, bank_sel}, {6'b0, e[4:3]});
      chk({tag, "/busy"}, {7'b0, busy}, {7'b0, m_busy});
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask

   task automatic clear_in();
      rst = 1'b0; psw_set = 2'b00; cy_in = 1'b0; ac_in = 1'b0; ov_in = 1'b0;
      mc_start = 1'b0; mc_done = 1'b0; acc = 8'h00; wr = 1'b0; wr_bit = 1'b0;
      wr_addr = 8'h00; data_in = 8'h00; bit_in = 1'b0;
   endtask

   initial begin
      clear_in();
      for (int i = 0; i < 8; i++) m_bit[i] = 1'b0;
      m_busy = 1'b0;
      m_pending = 0;
      @(posedge clk);
      #1;

      rst = 1'b1; acc = 8'h07;
      tick("reset");
      chk("reset_const", data_out, 8'h01);
      clear_in();
      tick("reset_release");
      chk("release_const", data_out, 8'h00);

      psw_set = 2'b10; cy_in = 1'b1; ac_in = 1'b1; ov_in = 1'b0;
      tick("set10");
      chk("set10_const", data_out, 8'hC0);
      psw_set = 2'b11; cy_in = 1'b0; ov_in = 1'b1;
      tick("set11");
      chk("set11_const", data_out, 8'h44);

      clear_in();
      mc_start = 1'b1; psw_set = 2'b11; cy_in = 1'b1; ov_in = 1'b0;
      tick("mc_start");
      chk("mc_start_busy", {7'b0, busy}, 8'h01);
      chk("mc_start_hold", data_out, 8'h44);
      clear_in();
      for (int i = 0; i < 3; i++) tick("mc_wait");
      mc_done = 1'b1; cy_in = 1'b0; ov_in = 1'b1;
      tick("mc_done");
      chk("mc_done_const", data_out, 8'h44);
      clear_in();
      mc_done = 1'b1; cy_in = 1'b1; ov_in = 1'b0;
      tick("idle_done");
      clear_in();

      wr = 1'b1; data_in = 8'h18; wr_addr = 8'hD0;
      tick("byte_wr");
      chk("byte_wr_bank", {6'b0, bank_sel}, 8'h03);
      wr_bit = 1'b1; wr_addr = 8'hD7; bit_in = 1'b1;
      tick("bit_wr_cy");
      chk("bit_wr_cy_const", {7'b0, cy_out}, 8'h01);
      wr_addr = 8'hD0; bit_in = 1'b1;
      tick("bit_wr_p");
      wr_bit = 1'b0; wr_addr = 8'hE0; data_in = 8'hFF;
      tick("byte_wr_other");
      clear_in();

      psw_set = 2'b01; cy_in = 1'b0; wr = 1'b1; wr_bit = 1'b1; wr_addr = 8'hD7; bit_in = 1'b1;
      tick("coll_single");
      chk("coll_single_cy", {7'b0, cy_out}, 8'h01);
      clear_in();
      mc_start = 1'b1; psw_set = 2'b01;
      tick("coll_mc_start");
      clear_in();
      mc_done = 1'b1; cy_in = 1'b0; wr = 1'b1; wr_bit = 1'b1; wr_addr = 8'hD7; bit_in = 1'b1;
      tick("coll_mc_done");
      chk("coll_mc_cy", {7'b0, cy_out}, 8'h00);
      clear_in();

      mc_start = 1'b1; psw_set = 2'b10; cy_in = 1'b1; ac_in = 1'b1; ov_in = 1'b1;
      tick("rst_wait_start");
      clear_in();
      rst = 1'b1;
      tick("rst_wait_rst");
      clear_in();
      mc_done = 1'b1; cy_in = 1'b1; ac_in = 1'b1; ov_in = 1'b1;
      tick("rst_wait_done");
      chk("rst_wait_const", data_out, 8'h00);
      clear_in();

      wr = 1'b1; data_in = 8'h02; wr_addr = 8'hD0;
      tick("f1_wr");
      chk("f1_const", {7'b0, data_out[1]}, f1_writable() ? 8'h01 : 8'h00);
      clear_in();

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         rst      = ($urandom_range(0, 49) == 0);
         psw_set  = 2'($urandom_range(0, 3));
         cy_in    = 1'($urandom_range(0, 1));
         ac_in    = 1'($urandom_range(0, 1));
         ov_in    = 1'($urandom_range(0, 1));
         mc_start = ($urandom_range(0, 5) == 0);
         mc_done  = ($urandom_range(0, 3) == 0);
         acc      = 8'($urandom);
         wr       = ($urandom_range(0, 2) == 0);
         wr_bit   = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       wr_addr = 8'hD0;
            1, 2:    wr_addr = 8'hD0 | 8'($urandom_range(0, 7));
            default: wr_addr = 8'($urandom);
         endcase
         data_in  = 8'($urandom);
         bit_in   = 1'($urandom_range(0, 1));
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
